// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Pipeline stall/flush/bubble sequencing for RAW hazards, taken
//               branches and multi-cycle data-memory accesses, with memory
//               timeout halt and a saturating stall-cycle counter.
//               Optional macro HAZARD_FWD_EN: forwarding present, stall on
//               load-use only.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int REG_W       = 4,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             two_src,
  input  logic             id_valid,
  input  logic [REG_W-1:0] ex_dst,
  input  logic             ex_wb_en,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] mem_dst,
  input  logic             mem_wb_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_front,
  output logic             flush_if,
  output logic             bubble_id,
  output logic             freeze_back,
  output logic             mem_err,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int c_WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [c_WAIT_W-1:0] c_TIMEOUT  = c_WAIT_W'(MEM_TIMEOUT);
  localparam logic [c_WAIT_W-1:0] c_WAIT_ONE = c_WAIT_W'(1);
  localparam logic [CNT_W-1:0]    c_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]    c_CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic [c_WAIT_W-1:0] w_wait_cnt_nxt;
  logic                r_mem_err;
  logic                w_mem_err_nxt;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic                w_raw_hazard;
  logic                w_freeze_front;
  logic                w_flush_if;
  logic                w_bubble_id;
  logic                w_freeze_back;

`ifdef HAZARD_FWD_EN
  // Forwarding covers everything except a load whose data is not yet available.
  assign w_raw_hazard = id_valid & ex_wb_en & ex_mem_read &
                        ((src1 == ex_dst) | (two_src & (src2 == ex_dst)));
`else
  assign w_raw_hazard = id_valid &
                        ((ex_wb_en  & (src1 == ex_dst))  |
                         (mem_wb_en & (src1 == mem_dst)) |
                         (two_src & ex_wb_en  & (src2 == ex_dst)) |
                         (two_src & mem_wb_en & (src2 == mem_dst)));
`endif

  always_comb begin
    w_freeze_front = 1'b0;
    w_flush_if     = 1'b0;
    w_bubble_id    = 1'b0;
    w_freeze_back  = 1'b0;
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_mem_err_nxt  = r_mem_err;
    case (r_state)
      ST_RUN: begin
        if (mem_req & ~mem_ready) begin
          w_freeze_front = 1'b1;
          w_freeze_back  = 1'b1;
          w_state_nxt    = ST_MEM_WAIT;
          w_wait_cnt_nxt = c_WAIT_ONE;
        end else if (branch_taken) begin
          // The ID instruction is squashed, so its hazard no longer matters.
          w_flush_if  = 1'b1;
          w_bubble_id = 1'b1;
        end else if (w_raw_hazard) begin
          w_freeze_front = 1'b1;
          w_bubble_id    = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          w_state_nxt    = ST_RUN;
          w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt < c_TIMEOUT) begin
          w_freeze_front = 1'b1;
          w_freeze_back  = 1'b1;
          w_wait_cnt_nxt = r_wait_cnt + c_WAIT_ONE;
        end else begin
          w_freeze_front = 1'b1;
          w_freeze_back  = 1'b1;
          w_state_nxt    = ST_HALT;
          w_mem_err_nxt  = 1'b1;
        end
      end
      ST_HALT: begin
        w_freeze_front = 1'b1;
        w_freeze_back  = 1'b1;
      end
      default: begin
        w_state_nxt    = ST_RUN;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_wait_cnt  <= '0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_mem_err  <= w_mem_err_nxt;
      if (w_freeze_front && (r_stall_cnt != c_CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
      end
    end
  end

  assign freeze_front = w_freeze_front;
  assign flush_if     = w_flush_if;
  assign bubble_id    = w_bubble_id;
  assign freeze_back  = w_freeze_back;
  assign mem_err      = r_mem_err;
  assign state        = r_state;
  assign stall_cnt    = r_stall_cnt;

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline controller that sequences the IF/ID and ID/EX pipeline registers and those after them.
- Issues stall (freeze) and bubble/flush controls for three events: register RAW hazards, taken branches resolved in EX, and multi-cycle data-memory accesses.
- Runs a memory-wait state machine with a timeout; a timeout halts the pipeline.
- Keeps a saturating count of stall cycles for performance debug.

Parameters:
REG_W, 4, register-index width; matches the register-file address width.
CNT_W, 16, width of the stall-cycle counter.
MEM_TIMEOUT, 64, maximum number of consecutive memory-wait cycles before halt (≥2).

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  synchronous active-high reset.
src1  input  REG_W  first source register index of the instruction in ID.
src2  input  REG_W  second source register index of the instruction in ID.
two_src  input  1  instruction in ID reads src2.
id_valid  input  1  ID holds a real instruction; when low, no RAW check.
ex_dst  input  REG_W  destination register index in EX.
ex_wb_en  input  1  EX instruction writes back.
ex_mem_read  input  1  EX instruction is a load.
mem_dst  input  REG_W  destination register index in MEM.
mem_wb_en  input  1  MEM instruction writes back.
branch_taken  input  1  taken branch resolved in EX this cycle.
mem_req  input  1  MEM stage accesses data memory this cycle.
mem_ready  input  1  data memory completes the access this cycle.
freeze_front  output  1  hold PC and IF/ID register.
flush_if  output  1  IF/ID register loads a NOP next edge.
bubble_id  output  1  ID/EX register loads zeroed control bits (WB_en, mem_read, mem_write, B, update) next edge.
freeze_back  output  1  hold ID/EX and EX/MEM; MEM/WB loads a bubble.
mem_err  output  1  sticky memory-timeout flag.
state  output  2  FSM state: 0=RUN, 1=MEM_WAIT, 2=HALT.
stall_cnt  output  CNT_W  saturating count of cycles with freeze_front=1.

Behaviour:
- Control outputs are Mealy/combinational from state plus inputs; they take effect at the next clk edge. No added latency.
- Reset: state=RUN, wait counter=0, stall_cnt=0, mem_err=0.
- Reset when no hazard or memory event is present: all control outputs 0.
- Reset mid-wait or in HALT returns to RUN on the same edge and clears all counters.
- raw_hazard (HAZARD_FWD_EN undefined):
  - id_valid & [(ex_wb_en & src1==ex_dst) | (mem_wb_en & src1==mem_dst) | (two_src & ex_wb_en & src2==ex_dst) | (two_src & mem_wb_en & src2==mem_dst)].
- RUN, priority high to low:
  1. mem_req & !mem_ready: freeze_front=1, freeze_back=1, flush/bubble=0. Next state MEM_WAIT; wait counter := 1.
  2. branch_taken: flush_if=1, bubble_id=1, no freeze. Stay RUN. Any concurrent raw_hazard is ignored because the ID instruction is squashed.
  3. raw_hazard: freeze_front=1, bubble_id=1. Stay RUN.
  4. Otherwise: all 0.
- MEM_WAIT:
  - mem_ready=1: all controls 0 that cycle (pipeline advances). Next state RUN.
  - mem_ready=0 and wait counter < MEM_TIMEOUT: freeze_front=freeze_back=1; wait counter increments.
  - mem_ready=0 and wait counter == MEM_TIMEOUT: next state HALT, mem_err:=1.
  - branch_taken and raw_hazard are ignored in MEM_WAIT. EX is frozen, so they are re-evaluated in RUN.
- HALT: freeze_front=freeze_back=1, flush/bubble=0. Stays until rst; mem_err stays 1.
- stall_cnt increments on every edge where freeze_front=1. It saturates at 2^CNT_W-1 with no wrap.
- A single-cycle access (mem_req & mem_ready in RUN) causes no stall.

Optional Feature:
HAZARD_FWD_EN:
- Defined: a forwarding unit exists. raw_hazard reduces to load-use only: id_valid & ex_wb_en & ex_mem_read & (src1==ex_dst | (two_src & src2==ex_dst)). MEM-stage matches never stall.
- Undefined: full RAW check as above.

Test Plan:
- Reset, then idle inputs -> state=0, all controls 0, stall_cnt=0.
- RAW on EX: src1=3, ex_dst=3, ex_wb_en=1, id_valid=1 for 1 cycle.
  - Flag undefined: freeze_front=1, bubble_id=1, stall_cnt=1 next cycle.
  - Flag defined with ex_mem_read=0: no stall.
- Branch and hazard in the same cycle: branch_taken=1 with matching src2=5 / mem_dst=5, two_src=1 -> flush_if=1, bubble_id=1, freeze_front=0.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then ready.
  - freeze_back=1 for 3 cycles; state 0→1→1→1→0.
  - Controls 0 on the ready cycle; stall_cnt=3.
- Timeout with MEM_TIMEOUT=4: mem_req=1, mem_ready never.
  - state=2 after 4 wait cycles; mem_err=1; freeze held.
  - rst pulse -> state=0, mem_err=0, stall_cnt=0.
- Saturation with CNT_W=4: hold a hazard 20 cycles -> stall_cnt stops at 15.
